// File: rtl/sort_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sort_frame_sequencer                                                       |
// | Loads a key frame, lets the external sorting network settle, and streams   |
// | the sorted keys out in ascending order.                                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sort_frame_sequencer #(
  parameter int WIDTH    = 3,
  parameter int N        = 64,
  parameter int SORT_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic [N*WIDTH-1:0]   net_in,
  input  logic [N*WIDTH-1:0]   net_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [$clog2(N):0]   frame_len,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  localparam int LW = IW + 1;
  localparam int TW = (SORT_LAT < 2) ? 1 : $clog2(SORT_LAT + 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] key_buf_q [N];
  logic [WIDTH-1:0] key_buf_d [N];
  logic [WIDTH-1:0] res_q [N];
  logic [WIDTH-1:0] res_d [N];
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    rd_idx_q, rd_idx_d;
  logic [LW-1:0]    frame_len_q, frame_len_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  always_comb begin
    state_d     = state_q;
    key_buf_d   = key_buf_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    rd_idx_d    = rd_idx_q;
    frame_len_d = frame_len_q;
    timer_d     = timer_q;

    case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          key_buf_d[cnt_q[IW-1:0]] = in_data;
          cnt_d = cnt_q + LW'(1);
          if (in_last || (cnt_q == LW'(N - 1))) begin
            frame_len_d = cnt_q + LW'(1);
            timer_d     = TW'(SORT_LAT);
            state_d     = S_SORT;
          end
        end
      end
      S_SORT: begin
        if (timer_q == TW'(1)) begin
          for (int k = 0; k < N; k++) res_d[k] = net_out[k*WIDTH +: WIDTH];
          state_d = S_DRAIN;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (rd_idx_q == frame_len_q - LW'(1)) begin
            rd_idx_d = '0;
            cnt_d    = '0;
            // Refill with the max key so unused slots sort above real keys.
            for (int k = 0; k < N; k++) key_buf_d[k] = '1;
            state_d  = S_LOAD;
          end else begin
            rd_idx_d = rd_idx_q + LW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_DRAIN);
    busy_d      = (state_d != S_LOAD);
    out_data_d  = out_valid_d ? res_d[rd_idx_d[IW-1:0]] : '0;
    out_last_d  = out_valid_d && (rd_idx_d == frame_len_d - LW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      for (int k = 0; k < N; k++) begin
        key_buf_q[k] <= '1;
        res_q[k]     <= '1;
      end
      cnt_q       <= '0;
      rd_idx_q    <= '0;
      frame_len_q <= '0;
      timer_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      key_buf_q   <= key_buf_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      rd_idx_q    <= rd_idx_d;
      frame_len_q <= frame_len_d;
      timer_q     <= timer_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    assign net_in[k*WIDTH +: WIDTH] = key_buf_q[k];
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign frame_len = frame_len_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sort_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sort_frame_sequencer                                                    |
// | Bench for sort_frame_sequencer with a behavioural sorting network.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sort_frame_sequencer;

  localparam int W   = 3;
  localparam int N   = 64;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready, in_last;
  logic [W-1:0]   in_data;
  logic [N*W-1:0] net_in, net_out;
  logic           out_valid, out_ready, out_last;
  logic [W-1:0]   out_data;
  logic [6:0]     frame_len;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] tx_q[$];
  logic [W-1:0] rx_q[$];
  logic [W-1:0] exp_q[$];
  bit           rxl_q[$];
  int           first_lat;
  int           hold_viol;

  sort_frame_sequencer #(.WIDTH(W), .N(N), .SORT_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .net_in(net_in), .net_out(net_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_len(frame_len), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational network: ascending, slot 0 smallest.
  function automatic logic [N*W-1:0] net_model(input logic [N*W-1:0] v);
    logic [N*W-1:0] r;
    int p;
    r = '0;
    p = 0;
    for (int j = 0; j < 2**W; j++)
      for (int k = 0; k < N; k++)
        if (v[k*W +: W] == W'(j)) begin
          r[p*W +: W] = W'(j);
          p++;
        end
    return r;
  endfunction

  assign net_out = net_model(net_in);

  function automatic void build_expected();
    logic [W-1:0] t;
    exp_q = tx_q;
    for (int a = 0; a < exp_q.size(); a++)
      for (int b = 0; b + 1 < exp_q.size() - a; b++)
        if (exp_q[b] > exp_q[b+1]) begin
          t = exp_q[b]; exp_q[b] = exp_q[b+1]; exp_q[b+1] = t;
        end
  endfunction

  function automatic int data_errors();
    int e = 0;
    if (rx_q.size() != exp_q.size()) return 1000;
    for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  // Index of the single out_last beat, or -2 if there is not exactly one.
  function automatic int last_pos();
    int n = 0, p = -2;
    for (int i = 0; i < rxl_q.size(); i++) if (rxl_q[i]) begin n++; p = i; end
    return (n == 1) ? p : -2;
  endfunction

  task automatic send_frame(input bit use_last, input bit gaps);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    while (i < tx_q.size() && guard < 2000) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; in_data = W'($urandom); in_last = 1'($urandom);
      end else begin
        in_valid = 1'b1; in_data = tx_q[i]; in_last = use_last && (i == tx_q.size() - 1);
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) i++;
      guard++;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (i != tx_q.size()) begin
      failures++;
      $display("FAIL send_timeout: accepted %0d keys, required %0d", i, tx_q.size());
    end
  endtask

  // mode 0: always ready, 1: alternate ready, 2: random ready
  task automatic collect(input int n, input int mode);
    int           lat = 0;
    int           guard = 0;
    bit           prev_stalled = 0;
    logic [W-1:0] prev_data = '0;
    logic         prev_last = 0;
    rx_q.delete(); rxl_q.delete();
    first_lat = -1;
    hold_viol = 0;
    while (rx_q.size() < n && guard < 3000) begin
      @(negedge clk);
      lat++;
      if (prev_stalled && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        hold_viol++;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(lat % 2) : 1'($urandom);
      if (out_valid && first_lat < 0) first_lat = lat;
      if (out_valid && out_ready) begin
        rx_q.push_back(out_data);
        rxl_q.push_back(out_last);
      end
      prev_stalled = out_valid && !out_ready;
      prev_data    = out_data;
      prev_last    = out_last;
      guard++;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (rx_q.size() != n) begin
      failures++;
      $display("FAIL collect_timeout: got %0d keys, required %0d", rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (frame_len !== 7'd0) begin failures++; $display("FAIL reset_frame_len: got %0d required 0", frame_len); end
    checks++; if (out_data !== 3'd0 || out_last !== 1'b0) begin failures++; $display("FAIL reset_out_data: got %0d/%b required 0/0", out_data, out_last); end
    checks++; if (net_in !== {N*W{1'b1}}) begin failures++; $display("FAIL reset_net_in: got %h required all-ones", net_in); end
  endtask

  task automatic test_full_frame();
    tx_q.delete();
    for (int i = 0; i < N; i++) tx_q.push_back(W'(7 - (i % 8)));
    build_expected();
    send_frame(1'b0, 1'b0);
    collect(N, 0);
    checks++; if (data_errors() != 0) begin failures++; $display("FAIL full_data: got %0d errors required 0", data_errors()); end
    checks++; if (last_pos() != N - 1) begin failures++; $display("FAIL full_last: got %0d required %0d", last_pos(), N - 1); end
    checks++; if (frame_len !== 7'd64) begin failures++; $display("FAIL full_frame_len: got %0d required 64", frame_len); end
    checks++; if (first_lat != LAT + 1) begin failures++; $display("FAIL full_latency: got %0d required %0d", first_lat, LAT + 1); end
  endtask

  task automatic test_short_frame();
    tx_q = '{3'd5, 3'd1, 3'd7, 3'd0, 3'd3};
    build_expected();
    send_frame(1'b1, 1'b0);
    collect(5, 0);
    checks++; if (data_errors() != 0) begin failures++; $display("FAIL short_data: got %0d errors required 0", data_errors()); end
    checks++; if (last_pos() != 4) begin failures++; $display("FAIL short_last: got %0d required 4", last_pos()); end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL short_return: got ready=%b valid=%b required 1/0", in_ready, out_valid); end
    checks++; if (net_in !== {N*W{1'b1}}) begin failures++; $display("FAIL short_refill: got %h required all-ones", net_in); end
  endtask

  task automatic test_dup_max();
    tx_q = '{3'd7, 3'd7, 3'd2};
    build_expected();
    send_frame(1'b1, 1'b0);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL dup_sort_state: got busy=%b ready=%b required 1/0", busy, in_ready); end
    collect(3, 0);
    checks++; if (data_errors() != 0) begin failures++; $display("FAIL dup_data: got %0d errors required 0", data_errors()); end
    checks++; if (last_pos() != 2) begin failures++; $display("FAIL dup_last: got %0d required 2", last_pos()); end
    checks++; if (frame_len !== 7'd3) begin failures++; $display("FAIL dup_frame_len: got %0d required 3", frame_len); end
  endtask

  task automatic test_backpressure();
    tx_q = '{3'd5, 3'd1, 3'd7, 3'd0, 3'd3};
    build_expected();
    send_frame(1'b1, 1'b1);
    collect(5, 1);
    checks++; if (data_errors() != 0) begin failures++; $display("FAIL bp_data: got %0d errors required 0", data_errors()); end
    checks++; if (hold_viol != 0) begin failures++; $display("FAIL bp_hold: got %0d unstable cycles required 0", hold_viol); end
    checks++; if (last_pos() != 4) begin failures++; $display("FAIL bp_last: got %0d required 4", last_pos()); end
  endtask

  task automatic test_back_to_back();
    tx_q = '{3'd4};
    build_expected();
    send_frame(1'b1, 1'b0);
    collect(1, 0);
    checks++; if (data_errors() != 0 || last_pos() != 0) begin failures++; $display("FAIL single_key: got %0d errors last=%0d required 0/0", data_errors(), last_pos()); end
    tx_q = '{3'd6, 3'd2};
    build_expected();
    send_frame(1'b1, 1'b0);
    collect(2, 0);
    checks++; if (data_errors() != 0 || last_pos() != 1) begin failures++; $display("FAIL b2b_second: got %0d errors last=%0d required 0/1", data_errors(), last_pos()); end
    checks++; if (frame_len !== 7'd2) begin failures++; $display("FAIL b2b_frame_len: got %0d required 2", frame_len); end
  endtask

  task automatic test_reset_mid_drain();
    tx_q = '{3'd5, 3'd1, 3'd7, 3'd0, 3'd3};
    send_frame(1'b1, 1'b0);
    collect(2, 0);
    checks++; if (out_valid !== 1'b1 || out_data !== 3'd3) begin failures++; $display("FAIL mid_drain_state: got valid=%b data=%0d required 1/3", out_valid, out_data); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL async_reset: got valid=%b busy=%b required 0/0", out_valid, busy); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || frame_len !== 7'd0) begin failures++; $display("FAIL post_reset: got ready=%b len=%0d required 1/0", in_ready, frame_len); end
    checks++; if (net_in !== {N*W{1'b1}}) begin failures++; $display("FAIL post_reset_net_in: got %h required all-ones", net_in); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int  len;
      bit  use_last;
      len = $urandom_range(1, N);
      use_last = (len < N) ? 1'b1 : 1'($urandom);
      tx_q.delete();
      for (int i = 0; i < len; i++)
        tx_q.push_back(($urandom_range(0, 3) == 0) ? 3'd7 : W'($urandom));
      build_expected();
      send_frame(use_last, 1'($urandom));
      collect(len, 2);
      checks++; if (data_errors() != 0) begin failures++; $display("FAIL rand_data f%0d: got %0d errors required 0", f, data_errors()); end
      checks++; if (last_pos() != len - 1) begin failures++; $display("FAIL rand_last f%0d: got %0d required %0d", f, last_pos(), len - 1); end
      checks++; if (frame_len !== 7'(len)) begin failures++; $display("FAIL rand_frame_len f%0d: got %0d required %0d", f, frame_len, len); end
      checks++; if (hold_viol != 0) begin failures++; $display("FAIL rand_hold f%0d: got %0d required 0", f, hold_viol); end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_dup_max();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
